// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - HD44780-style LCD bus sequencer with power-on init and valid/ready command port
// One shared counter times every state; it restarts at zero on state entry and never wraps.

module lcd_ctrl #(
  parameter int unsigned T_PWRUP = 750000,
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_EN    = 12,
  parameter int unsigned T_CMD   = 2000,
  parameter int unsigned T_LONG  = 82000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_cmd_valid,
  input  logic       i_cmd_rs,
  input  logic [7:0] i_cmd_data,
  output logic       o_cmd_ready,
  input  logic       i_lcd_on,
  output logic       o_lcd_on,
  output logic       o_lcd_en,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic [7:0] o_lcd_data,
  output logic       o_busy,
  output logic       o_init_done
);

  localparam int unsigned T_MAX_A = (T_PWRUP > T_LONG) ? T_PWRUP : T_LONG;
  localparam int unsigned T_MAX_B = (T_CMD > T_EN) ? T_CMD : T_EN;
  localparam int unsigned T_MAX_C = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int unsigned T_MAX   = (T_MAX_C > T_SETUP) ? T_MAX_C : T_SETUP;
  localparam int unsigned CW      = $clog2(T_MAX) + 1;

  localparam logic [CW-1:0] PWRUP_LAST = CW'(T_PWRUP - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] EN_LAST    = CW'(T_EN - 1);
  localparam logic [CW-1:0] CMD_LAST   = CW'(T_CMD - 1);
  localparam logic [CW-1:0] LONG_LAST  = CW'(T_LONG - 1);

  typedef enum logic [2:0] {
    S_PWRUP,
    S_ISSUE,
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          en_q, en_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          init_done_q, init_done_d;
  logic          lcd_on_q;
  logic          long_cmd;
  logic [CW-1:0] wait_last;
  logic [2:0]    idx_inc;

  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    case (idx)
      2'd0:    init_rom = 8'h38;
      2'd1:    init_rom = 8'h0C;
      2'd2:    init_rom = 8'h01;
      default: init_rom = 8'h06;
    endcase
  endfunction

  // Clear (01) and return-home (02/03) need the long execution delay.
  always_comb begin
    long_cmd  = !rs_q && (data_q inside {8'h01, 8'h02, 8'h03});
    wait_last = long_cmd ? LONG_LAST : CMD_LAST;
    idx_inc   = idx_q + 3'd1;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    en_d        = en_q;
    rs_d        = rs_q;
    data_d      = data_q;
    ready_d     = ready_q;
    init_done_d = init_done_q;

    case (state_q)
      S_PWRUP: begin
        if (cnt_q == PWRUP_LAST) begin
          state_d = S_ISSUE;
          cnt_d   = '0;
          idx_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ISSUE: begin
        rs_d    = 1'b0;
        data_d  = init_rom(idx_q[1:0]);
        state_d = S_SETUP;
        cnt_d   = '0;
      end
      S_IDLE: begin
        if (i_cmd_valid && ready_q) begin
          rs_d    = i_cmd_rs;
          data_d  = i_cmd_data;
          ready_d = 1'b0;
          state_d = S_SETUP;
          cnt_d   = '0;
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = S_PULSE;
          en_d    = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PULSE: begin
        if (cnt_q == EN_LAST) begin
          state_d = S_WAIT;
          en_d    = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT: begin
        if (cnt_q == wait_last) begin
          cnt_d = '0;
          if (!init_done_q) begin
            idx_d = idx_inc;
            if (idx_inc < 3'd4) begin
              state_d = S_ISSUE;
            end else begin
              init_done_d = 1'b1;
              ready_d     = 1'b1;
              state_d     = S_IDLE;
            end
          end else begin
            ready_d = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_PWRUP;
        cnt_d   = '0;
      end
    endcase

    busy_d = !ready_d;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= S_PWRUP;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      en_q        <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      ready_q     <= 1'b0;
      busy_q      <= 1'b1;
      init_done_q <= 1'b0;
      lcd_on_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      en_q        <= en_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
      lcd_on_q    <= i_lcd_on;
    end
  end

  assign o_cmd_ready = ready_q;
  assign o_busy      = busy_q;
  assign o_init_done = init_done_q;
  assign o_lcd_en    = en_q;
  assign o_lcd_rs    = rs_q;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_data  = data_q;
  assign o_lcd_on    = lcd_on_q;

endmodule
